// File: rtl/pe_link_arbiter_if.sv
// Handshake and status bundle for the three-way link arbiter.
// The arbiter side uses master; the traffic sources and sink use slave.
interface pe_link_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 128
);
  logic                    ap_start;
  logic [2:0]              in_valid;
  logic [3*DATA_WIDTH-1:0] in_data;
  logic [2:0]              in_last;
  logic [2:0]              in_ready;
  logic [DATA_WIDTH-1:0]   out_data;
  logic                    out_last;
  logic                    out_valid;
  logic                    out_ready;
  logic [1:0]              grant_id;
  logic                    busy;
  logic [15:0]             pkt_count;

  modport master (
    input  ap_start, in_valid, in_data, in_last, out_ready,
    output in_ready, out_data, out_last, out_valid, grant_id, busy, pkt_count
  );

  modport slave (
    output ap_start, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_data, out_last, out_valid, grant_id, busy, pkt_count
  );
endinterface

// File: rtl/pe_link_arbiter.sv
// Packet-granular round-robin arbiter merging west, east and local streams
// onto one registered output link; one arbitration cycle between packets.
module pe_link_arbiter #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned NUM_REQ    = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  pe_link_arbiter_if.master    link
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            rr_ptr_q, rr_ptr_d;
  logic [1:0]            grant_q, grant_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;
  logic                  out_valid_q, out_valid_d;
  logic [15:0]           pkt_count_q, pkt_count_d;

  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  can_take;
  logic                  accept;
  logic [NUM_REQ-1:0]    ready_vec;
  logic                  found;
  logic [1:0]            pick;
  logic [1:0]            cand;
  logic [2:0]            sum;

  // Payload mux for the current grantee.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant_q == 2'(k)) begin
        sel_valid = link.in_valid[k];
        sel_last  = link.in_last[k];
        sel_data  = link.in_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // First valid requester searching upward (mod 3) from rr_ptr.
  always_comb begin
    found = 1'b0;
    pick  = rr_ptr_q;
    cand  = '0;
    sum   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      sum  = {1'b0, rr_ptr_q} + 3'(i);
      cand = (sum >= 3'(NUM_REQ)) ? 2'(sum - 3'(NUM_REQ)) : sum[1:0];
      if (!found && link.in_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign can_take = (state_q == BUSY) && (!out_valid_q || link.out_ready);
  assign accept   = can_take && sel_valid;

  always_comb begin
    ready_vec = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      ready_vec[k] = can_take && (grant_q == 2'(k));
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    pkt_count_d = pkt_count_q;

    // Output slot: a fresh beat overrides the drain, giving back-to-back flow.
    if (accept) begin
      out_data_d  = sel_data;
      out_last_d  = sel_last;
      out_valid_d = 1'b1;
    end else if (out_valid_q && link.out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (link.ap_start && found) begin
          grant_d = pick;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (accept && sel_last) begin
          state_d     = IDLE;
          rr_ptr_d    = (grant_q == 2'(NUM_REQ - 1)) ? '0 : grant_q + 2'd1;
          pkt_count_d = pkt_count_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  assign link.in_ready  = ready_vec;
  assign link.out_data  = out_data_q;
  assign link.out_last  = out_last_q;
  assign link.out_valid = out_valid_q;
  assign link.grant_id  = grant_q;
  assign link.busy      = (state_q == BUSY);
  assign link.pkt_count = pkt_count_q;

endmodule

// File: tb/tb_pe_link_arbiter.sv
// Bench for pe_link_arbiter: vector table, directed corner sequences and a
// randomized run against a packet-level reference model.
module tb_pe_link_arbiter;
  localparam int DW = 128;
  typedef logic [DW-1:0] w_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pe_link_arbiter_if #(.DATA_WIDTH(DW)) ifc ();

  pe_link_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(3)) dut (
    .clk   (clk),
    .reset (reset),
    .link  (ifc)
  );

  int total  = 0;
  int passed = 0;

  task automatic chk(input string name, input w_t act, input w_t exp);
    total++;
    if (act !== exp) $display("FAIL %s: actual %0h required %0h", name, act, exp);
    else passed++;
  endtask

  task automatic set_in(input logic ap, input logic [2:0] v, input logic [2:0] l, input logic ordy);
    ifc.ap_start  = ap;
    ifc.in_valid  = v;
    ifc.in_last   = l;
    ifc.out_ready = ordy;
  endtask

  task automatic do_reset();
    set_in(1'b0, 3'b000, 3'b000, 1'b0);
    ifc.in_data = '0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    logic       ap;
    logic [2:0] valid;
    logic [2:0] last;
    logic       ordy;
    logic [2:0] exp_ir;
    logic       exp_busy;
    logic [1:0] exp_grant;
    logic       exp_ov;
    w_t         exp_data;
    logic [15:0] exp_pkt;
  } vec_t;

  function automatic vec_t mk(logic ap, logic [2:0] v, logic [2:0] ir, logic b,
                              logic [1:0] g, logic ov, w_t d, logic [15:0] p);
    vec_t r;
    r.ap = ap; r.valid = v; r.last = 3'b111; r.ordy = 1'b1;
    r.exp_ir = ir; r.exp_busy = b; r.exp_grant = g; r.exp_ov = ov;
    r.exp_data = d; r.exp_pkt = p;
    return r;
  endfunction

  // Random-phase reference model state
  logic        mbusy, mslot_v, mslot_last, mready, acc, beat_l;
  logic [1:0]  mgrant, mrr;
  logic [15:0] mcnt;
  w_t          mslot_d, beat_d;
  logic [2:0]  exp_ir;
  int          slen[3];
  int          sidx[3];
  w_t          sdata[3][4];

  task automatic new_pkt(input int k);
    slen[k] = int'($urandom_range(1, 4));
    sidx[k] = 0;
    for (int b = 0; b < 4; b++) sdata[k][b] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    vec_t tbl[16];
    w_t   dk[3];
    w_t   d34[4];
    w_t   d35[3];
    int   g, c, pk;
    logic fnd;

    for (int k = 0; k < 3; k++) dk[k] = w_t'(128'h1000 + k);
    tbl[0]  = mk(1, 3'b111, 3'b000, 1, 2'd0, 0, '0,    16'd0);
    tbl[1]  = mk(1, 3'b111, 3'b001, 0, 2'd0, 1, dk[0], 16'd1);
    tbl[2]  = mk(1, 3'b111, 3'b000, 1, 2'd1, 0, dk[0], 16'd1);
    tbl[3]  = mk(1, 3'b111, 3'b010, 0, 2'd1, 1, dk[1], 16'd2);
    tbl[4]  = mk(1, 3'b111, 3'b000, 1, 2'd2, 0, dk[1], 16'd2);
    tbl[5]  = mk(1, 3'b111, 3'b100, 0, 2'd2, 1, dk[2], 16'd3);
    tbl[6]  = mk(1, 3'b111, 3'b000, 1, 2'd0, 0, dk[2], 16'd3);
    tbl[7]  = mk(1, 3'b111, 3'b001, 0, 2'd0, 1, dk[0], 16'd4);
    tbl[8]  = mk(1, 3'b111, 3'b000, 1, 2'd1, 0, dk[0], 16'd4);
    tbl[9]  = mk(1, 3'b111, 3'b010, 0, 2'd1, 1, dk[1], 16'd5);
    tbl[10] = mk(1, 3'b111, 3'b000, 1, 2'd2, 0, dk[1], 16'd5);
    tbl[11] = mk(1, 3'b111, 3'b100, 0, 2'd2, 1, dk[2], 16'd6);
    tbl[12] = mk(0, 3'b111, 3'b000, 0, 2'd2, 0, dk[2], 16'd6);
    tbl[13] = mk(1, 3'b000, 3'b000, 0, 2'd2, 0, dk[2], 16'd6);
    tbl[14] = mk(1, 3'b001, 3'b000, 1, 2'd0, 0, dk[2], 16'd6);
    tbl[15] = mk(1, 3'b001, 3'b001, 0, 2'd0, 1, dk[0], 16'd7);

    // Reset values
    do_reset();
    chk("rst_busy", w_t'(ifc.busy), '0);
    chk("rst_out_valid", w_t'(ifc.out_valid), '0);
    chk("rst_out_last", w_t'(ifc.out_last), '0);
    chk("rst_out_data", ifc.out_data, '0);
    chk("rst_pkt_count", w_t'(ifc.pkt_count), '0);
    chk("rst_grant", w_t'(ifc.grant_id), '0);
    chk("rst_in_ready", w_t'(ifc.in_ready), '0);

    // Round-robin table: single-beat packets from all three requesters
    ifc.in_data = {dk[2], dk[1], dk[0]};
    for (int i = 0; i < 16; i++) begin
      set_in(tbl[i].ap, tbl[i].valid, tbl[i].last, tbl[i].ordy);
      #1;
      chk($sformatf("tbl%0d_in_ready", i), w_t'(ifc.in_ready), w_t'(tbl[i].exp_ir));
      @(negedge clk);
      chk($sformatf("tbl%0d_busy", i), w_t'(ifc.busy), w_t'(tbl[i].exp_busy));
      chk($sformatf("tbl%0d_grant", i), w_t'(ifc.grant_id), w_t'(tbl[i].exp_grant));
      chk($sformatf("tbl%0d_out_valid", i), w_t'(ifc.out_valid), w_t'(tbl[i].exp_ov));
      chk($sformatf("tbl%0d_out_data", i), ifc.out_data, tbl[i].exp_data);
      chk($sformatf("tbl%0d_pkt", i), w_t'(ifc.pkt_count), w_t'(tbl[i].exp_pkt));
    end

    // Two-beat packet from east link
    do_reset();
    ifc.in_data[DW +: DW] = w_t'(128'hA);
    set_in(1, 3'b010, 3'b000, 1);
    @(negedge clk);
    chk("s32_grant", w_t'(ifc.grant_id), w_t'(2'd1));
    chk("s32_busy", w_t'(ifc.busy), w_t'(1'b1));
    chk("s32_ready0", w_t'(ifc.in_ready), w_t'(3'b010));
    @(negedge clk);
    chk("s32_ov0", w_t'(ifc.out_valid), w_t'(1'b1));
    chk("s32_data0", ifc.out_data, w_t'(128'hA));
    chk("s32_last0", w_t'(ifc.out_last), '0);
    ifc.in_data[DW +: DW] = w_t'(128'hB);
    ifc.in_last = 3'b010;
    #1 chk("s32_ready1", w_t'(ifc.in_ready), w_t'(3'b010));
    @(negedge clk);
    chk("s32_data1", ifc.out_data, w_t'(128'hB));
    chk("s32_last1", w_t'(ifc.out_last), w_t'(1'b1));
    chk("s32_ov1", w_t'(ifc.out_valid), w_t'(1'b1));
    chk("s32_busy_end", w_t'(ifc.busy), '0);
    chk("s32_pkt", w_t'(ifc.pkt_count), w_t'(16'd1));
    set_in(1, 3'b111, 3'b111, 1);
    @(negedge clk);
    chk("s32_rr_next", w_t'(ifc.grant_id), w_t'(2'd2));
    chk("s32_drained", w_t'(ifc.out_valid), '0);

    // Four-cycle downstream stall mid-packet
    do_reset();
    for (int b = 0; b < 4; b++) d34[b] = {$urandom, $urandom, $urandom, $urandom};
    ifc.in_data[0 +: DW] = d34[0];
    set_in(1, 3'b001, 3'b000, 1);
    @(negedge clk);
    @(negedge clk);
    chk("s34_data0", ifc.out_data, d34[0]);
    ifc.out_ready = 1'b0;
    ifc.in_data[0 +: DW] = d34[1];
    for (int s = 0; s < 4; s++) begin
      #1 chk($sformatf("s34_stall%0d_ready", s), w_t'(ifc.in_ready), '0);
      @(negedge clk);
      chk($sformatf("s34_stall%0d_ov", s), w_t'(ifc.out_valid), w_t'(1'b1));
      chk($sformatf("s34_stall%0d_data", s), ifc.out_data, d34[0]);
    end
    ifc.out_ready = 1'b1;
    for (int b = 1; b < 4; b++) begin
      ifc.in_data[0 +: DW] = d34[b];
      ifc.in_last = (b == 3) ? 3'b001 : 3'b000;
      #1 chk($sformatf("s34_b%0d_ready", b), w_t'(ifc.in_ready), w_t'(3'b001));
      @(negedge clk);
      chk($sformatf("s34_b%0d_data", b), ifc.out_data, d34[b]);
      chk($sformatf("s34_b%0d_ov", b), w_t'(ifc.out_valid), w_t'(1'b1));
      chk($sformatf("s34_b%0d_last", b), w_t'(ifc.out_last), w_t'(b == 3));
    end
    chk("s34_busy_end", w_t'(ifc.busy), '0);
    chk("s34_pkt", w_t'(ifc.pkt_count), w_t'(16'd1));

    // ap_start dropped after the first beat of a 3-beat packet
    do_reset();
    for (int b = 0; b < 3; b++) d35[b] = {$urandom, $urandom, $urandom, $urandom};
    ifc.in_data[2*DW +: DW] = d35[0];
    set_in(1, 3'b100, 3'b000, 1);
    @(negedge clk);
    @(negedge clk);
    chk("s35_data0", ifc.out_data, d35[0]);
    ifc.ap_start = 1'b0;
    for (int b = 1; b < 3; b++) begin
      ifc.in_data[2*DW +: DW] = d35[b];
      ifc.in_last = (b == 2) ? 3'b100 : 3'b000;
      @(negedge clk);
      chk($sformatf("s35_data%0d", b), ifc.out_data, d35[b]);
    end
    chk("s35_busy_end", w_t'(ifc.busy), '0);
    chk("s35_pkt", w_t'(ifc.pkt_count), w_t'(16'd1));
    ifc.in_valid = 3'b111;
    for (int s = 0; s < 3; s++) begin
      #1 chk($sformatf("s35_idle%0d_ready", s), w_t'(ifc.in_ready), '0);
      @(negedge clk);
      chk($sformatf("s35_idle%0d_busy", s), w_t'(ifc.busy), '0);
      chk($sformatf("s35_idle%0d_grant", s), w_t'(ifc.grant_id), w_t'(2'd2));
    end

    // Asynchronous reset with a held beat, then arbitration restarts at 0
    do_reset();
    set_in(1, 3'b010, 3'b010, 1);
    @(negedge clk);
    @(negedge clk);
    set_in(1, 3'b100, 3'b000, 1);
    @(negedge clk);
    @(negedge clk);
    ifc.out_ready = 1'b0;
    @(negedge clk);
    chk("s36_pre_ov", w_t'(ifc.out_valid), w_t'(1'b1));
    chk("s36_pre_busy", w_t'(ifc.busy), w_t'(1'b1));
    chk("s36_pre_pkt", w_t'(ifc.pkt_count), w_t'(16'd1));
    #2 reset = 1'b0;
    #1;
    chk("s36_ov", w_t'(ifc.out_valid), '0);
    chk("s36_busy", w_t'(ifc.busy), '0);
    chk("s36_pkt", w_t'(ifc.pkt_count), '0);
    chk("s36_ready", w_t'(ifc.in_ready), '0);
    @(negedge clk);
    reset = 1'b1;
    set_in(1, 3'b111, 3'b111, 1);
    @(negedge clk);
    chk("s31_restart_grant", w_t'(ifc.grant_id), '0);
    chk("s31_restart_busy", w_t'(ifc.busy), w_t'(1'b1));

    // Randomized traffic against the packet-level model
    do_reset();
    mbusy = 1'b0; mgrant = '0; mrr = '0; mcnt = '0;
    mslot_v = 1'b0; mslot_d = '0; mslot_last = 1'b0;
    for (int k = 0; k < 3; k++) new_pkt(k);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      chk("rnd_busy", w_t'(ifc.busy), w_t'(mbusy));
      chk("rnd_grant", w_t'(ifc.grant_id), w_t'(mgrant));
      chk("rnd_out_valid", w_t'(ifc.out_valid), w_t'(mslot_v));
      chk("rnd_out_data", ifc.out_data, mslot_d);
      chk("rnd_out_last", w_t'(ifc.out_last), w_t'(mslot_last));
      chk("rnd_pkt", w_t'(ifc.pkt_count), w_t'(mcnt));
      ifc.ap_start  = ($urandom_range(0, 7) != 0);
      ifc.out_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 3; k++) begin
        ifc.in_valid[k] = ($urandom_range(0, 2) != 0);
        ifc.in_data[k*DW +: DW] = sdata[k][sidx[k]];
        ifc.in_last[k] = (sidx[k] == slen[k] - 1);
      end
      #1;
      mready = mbusy && (!mslot_v || ifc.out_ready);
      exp_ir = mready ? (3'b001 << mgrant) : 3'b000;
      chk("rnd_in_ready", w_t'(ifc.in_ready), w_t'(exp_ir));
      g = int'(mgrant);
      acc = mready && ifc.in_valid[g];
      beat_d = sdata[g][sidx[g]];
      beat_l = (sidx[g] == slen[g] - 1);
      if (acc) begin
        mslot_v = 1'b1; mslot_d = beat_d; mslot_last = beat_l;
      end else if (mslot_v && ifc.out_ready) begin
        mslot_v = 1'b0;
      end
      if (!mbusy) begin
        fnd = 1'b0; pk = 0;
        for (int i = 0; i < 3; i++) begin
          c = (int'(mrr) + i) % 3;
          if (!fnd && ifc.in_valid[c]) begin fnd = 1'b1; pk = c; end
        end
        if (ifc.ap_start && fnd) begin mgrant = 2'(pk); mbusy = 1'b1; end
      end else if (acc) begin
        if (beat_l) begin
          mbusy = 1'b0; mrr = 2'((g + 1) % 3); mcnt = mcnt + 16'd1;
          new_pkt(g);
        end else begin
          sidx[g] = sidx[g] + 1;
        end
      end
      @(negedge clk);
    end

    // Packet counter wrap from 16'hFFFF
    do_reset();
    set_in(1, 3'b001, 3'b001, 1);
    force dut.pkt_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.pkt_count_q;
    chk("s37_preload", w_t'(ifc.pkt_count), w_t'(16'hFFFF));
    @(negedge clk);
    chk("s37_wrap", w_t'(ifc.pkt_count), '0);
    chk("s37_busy", w_t'(ifc.busy), '0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pe_link_arbiter.md
PE_LINK_ARBITER -- requirements
Module: pe_link_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128, meaning payload width per beat.
REQ-002 SHALL have parameter NUM_REQ, fixed 3, meaning the requesters: 0=west link, 1=east link, 2=local AXIS.
REQ-003 SHALL have port clk  input  1  sole clock; all state on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ap_start  input  1  enables new grants.
REQ-006 SHALL have port in_valid  input  3  per-requester beat valid.
REQ-007 SHALL have port in_data  input  3*DATA_WIDTH  packed payloads; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port in_last  input  3  per-requester end-of-packet flag.
REQ-009 SHALL have port in_ready  output  3  per-requester accept.
REQ-010 SHALL have port out_data  output  DATA_WIDTH  registered shared-link payload.
REQ-011 SHALL have port out_last  output  1  registered end-of-packet flag.
REQ-012 SHALL have port out_valid  output  1  registered link valid.
REQ-013 SHALL have port out_ready  input  1  downstream accept.
REQ-014 SHALL have port grant_id  output  2  current or most recent grantee index.
REQ-015 SHALL have port busy  output  1  high in state BUSY.
REQ-016 SHALL have port pkt_count  output  16  count of completed packets.

Function
REQ-017 SHALL implement a two-state FSM: IDLE and BUSY.
REQ-018 In IDLE with ap_start=1 and any in_valid set, SHALL register grant_id as the first set in_valid, searching from rr_ptr in the order rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3), and SHALL enter BUSY next cycle.
REQ-019 In IDLE with ap_start=0 or in_valid=0, SHALL remain in IDLE, and grant_id SHALL hold its value.
REQ-020 in_ready[grant_id] SHALL be (state==BUSY) && (!out_valid || out_ready); all other in_ready bits SHALL be 0; in IDLE all in_ready bits SHALL be 0.
REQ-021 A beat SHALL be accepted when in_valid[grant_id] && in_ready[grant_id]; out_data/out_last SHALL load the granted payload/last, and out_valid SHALL be 1 the next cycle (latency 1).
REQ-022 When out_valid && out_ready and no beat is accepted, out_valid SHALL clear next cycle; out_data/out_last SHALL hold.
REQ-023 While out_valid && !out_ready, out_data, out_last and out_valid SHALL hold unchanged.
REQ-024 Simultaneous drain and accept SHALL sustain one beat per cycle with no bubble.
REQ-025 Accepting a beat with last=1 SHALL return the FSM to IDLE, set rr_ptr to (grant_id+1) mod 3, and increment pkt_count, all the next cycle.
REQ-026 pkt_count SHALL wrap from 16'hFFFF to 0.
REQ-027 Deasserting ap_start during BUSY SHALL not abort the packet; it completes, then no new grant is issued.
REQ-028 Requests from non-granted requesters during BUSY SHALL be ignored until the next IDLE cycle; there is exactly one IDLE (arbitration) cycle between packets when requests are pending.
REQ-029 Changes to in_valid during the IDLE arbitration cycle SHALL affect only that cycle's decision.

Reset
REQ-030 reset=0 SHALL asynchronously force: state=IDLE, rr_ptr=0, grant_id=0, busy=0, out_valid=0, out_last=0, out_data=0, pkt_count=0, in_ready=0.
REQ-031 Reset mid-packet SHALL discard the packet and any held output beat; after release, arbitration restarts from requester 0.

Verification
REQ-032 Reset release, ap_start=1, in_valid=3'b010, 2-beat packet D0=0xA, D1=0xB(last), out_ready=1 -> grant_id=1; out_data 0xA then 0xB on consecutive cycles; out_last only on 0xB; pkt_count=1; rr_ptr=2.
REQ-033 All three requesters continuously valid, single-beat packets -> grant order 0,1,2,0,1,2; one IDLE cycle between packets.
REQ-034 out_ready=0 for 4 cycles mid-packet -> out_data/out_valid held; in_ready[grant_id]=0 during the stall; no beat lost or duplicated after out_ready=1.
REQ-035 ap_start dropped after first beat of a 3-beat packet -> packet completes, FSM stays IDLE, in_ready=0 while ap_start=0.
REQ-036 reset asserted while out_valid=1 in BUSY -> out_valid=0 and busy=0 immediately (asynchronous), pkt_count=0.
REQ-037 Preload 65535 completed packets, complete one more -> pkt_count=0.
